// File: rtl/baud_gen_ctrl_if.sv
// Divisor load channel between the host/config side and baud_gen_ctrl.
// The master offers a divisor with i_div_valid. The slave accepts it on any
// cycle where o_div_ready is also high.
interface baud_gen_ctrl_if #(
    parameter int N = 16
);
    logic [N-1:0] i_div;
    logic         i_div_valid;
    logic         o_div_ready;

    modport master (
        output i_div,
        output i_div_valid,
        input  o_div_ready
    );

    modport slave (
        input  i_div,
        input  i_div_valid,
        output o_div_ready
    );
endinterface

// File: rtl/baud_gen_ctrl.sv
// baud_gen_ctrl: programmable baud-tick scheduler for the UART datapath.
//
// A divisor counter produces a sample tick every div_reg cycles. An
// oversampling counter turns every OVS sample ticks into one bit tick.
// A new divisor loads straight into div_reg while the block is idle. While
// the block is counting, the new divisor is parked in a shadow register and
// committed at the next period boundary, so tick spacing never changes
// mid-period.
//
// Optional feature: define BAUD_GEN_CTRL_RESYNC_EN to add i_resync. This
// input restarts both counters for RX start-bit alignment.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | counters held at 0, no ticks, divisor loads go to div_reg
//   RUN   | counting with div_reg, a divisor load goes to shadow -> PEND
//   PEND  | counting with old div_reg; shadow commits on the next s_tick
module baud_gen_ctrl #(
    parameter int N           = 16,
    parameter int OVS         = 16,
    parameter int DEFAULT_DIV = 163
) (
    input  logic                 clk,
    input  logic                 reset,
    baud_gen_ctrl_if.slave       div_if,
    input  logic                 i_enable,
`ifdef BAUD_GEN_CTRL_RESYNC_EN
    input  logic                 i_resync,
`endif
    output logic                 o_s_tick,
    output logic                 o_bit_tick,
    output logic [N-1:0]         o_div_active,
    output logic [1:0]           o_state
);

    localparam int OW = (OVS > 1) ? $clog2(OVS) : 1;

    localparam logic [N-1:0]  DIV_RST = N'(DEFAULT_DIV);
    localparam logic [N-1:0]  DIV_MIN = N'(2);
    localparam logic [N-1:0]  CNT_ONE = N'(1);
    localparam logic [OW-1:0] OS_LAST = OW'(OVS - 1);
    localparam logic [OW-1:0] OS_ONE  = OW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]  os_cnt_q, os_cnt_d;
    logic [N-1:0]   div_reg_q, div_reg_d;
    logic [N-1:0]   shadow_q, shadow_d;

    logic           resync_req;
    logic           counting;
    logic           div_ready;
    logic           div_accept;
    logic [N-1:0]   div_clamped;
    logic           period_end;
    logic           s_tick;
    logic           bit_tick;

`ifdef BAUD_GEN_CTRL_RESYNC_EN
    // In IDLE the counters are already at 0 and no ticks are emitted,
    // so a resync request there has no effect.
    assign resync_req = i_resync;
`else
    assign resync_req = 1'b0;
`endif

    // Tick and handshake decode, derived from registered state only.
    // The one exception is the resync override.
    always_comb begin
        counting    = (state_q != ST_IDLE);
        div_ready   = (state_q != ST_PEND);
        div_accept  = div_if.i_div_valid && div_ready;
        div_clamped = (div_if.i_div < DIV_MIN) ? DIV_MIN : div_if.i_div;
        period_end  = counting && (cnt_q == (div_reg_q - CNT_ONE));
        s_tick      = period_end && !resync_req;
        bit_tick    = s_tick && (os_cnt_q == OS_LAST);
    end

    // Next-state computation for the FSM, the counters and the divisor registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        os_cnt_d  = os_cnt_q;
        div_reg_d = div_reg_q;
        shadow_d  = shadow_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                os_cnt_d = '0;
                if (div_accept) begin
                    div_reg_d = div_clamped;
                end
                if (i_enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_PEND: begin
                if (period_end) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end

                if (s_tick) begin
                    os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : (os_cnt_q + OS_ONE);
                end

                if (resync_req) begin
                    cnt_d    = '0;
                    os_cnt_d = '0;
                end

                if (state_q == ST_RUN) begin
                    if (div_accept) begin
                        shadow_d = div_clamped;
                    end
                    if (!i_enable) begin
                        // A divisor accepted as the block stops is committed directly.
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        os_cnt_d = '0;
                        if (div_accept) begin
                            div_reg_d = div_clamped;
                        end
                    end else if (div_accept) begin
                        state_d = ST_PEND;
                    end
                end else begin
                    if (!i_enable) begin
                        // Commit the pending divisor rather than dropping it.
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        os_cnt_d  = '0;
                        div_reg_d = shadow_q;
                    end else if (s_tick) begin
                        // Period boundary: switch divisor, os_cnt keeps its phase.
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        div_reg_d = shadow_q;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                os_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            os_cnt_q  <= '0;
            div_reg_q <= DIV_RST;
            shadow_q  <= DIV_RST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            os_cnt_q  <= os_cnt_d;
            div_reg_q <= div_reg_d;
            shadow_q  <= shadow_d;
        end
    end

    assign div_if.o_div_ready = div_ready;
    assign o_s_tick           = s_tick;
    assign o_bit_tick         = bit_tick;
    assign o_div_active       = div_reg_q;
    assign o_state            = state_q;

endmodule
